// File: rtl/window_count_detector.sv
// Serial-stream window detector: pulses when the trailing WIN accepted bits hold a programmed
// count of 1s (exact or at-least). Optional saturating hit counter enabled by WCD_HIT_CNT_EN.
module window_count_detector #(
    parameter int WIN   = 3,
    parameter int CW    = $clog2(WIN + 1),
    parameter int HIT_W = 16
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          enable,
    input  logic          in_valid,
    input  logic          serial_pattern,
    input  logic [CW-1:0] target_count,
    input  logic          cmp_mode,
    output logic          pattern_detected,
    output logic          window_full,
    output logic [CW-1:0] ones_count
`ifdef WCD_HIT_CNT_EN
    ,
    output logic [HIT_W-1:0] hit_count
`endif
);

    localparam logic [CW-1:0] WIN_CW = CW'(WIN);
    localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

    if ((WIN < 32'sd2) || (WIN > 32'sd64) || (HIT_W < 32'sd1)) begin : g_bad_params
        $error("window_count_detector: illegal WIN or HIT_W");
    end

    logic [WIN-1:0] hist_r;
    logic [CW-1:0]  fill_r;
    logic [CW-1:0]  ones_r;
    logic           window_full_r;
    logic           pattern_detected_r;

    logic           full_s;
    logic [CW-1:0]  add_s;
    logic [CW-1:0]  drop_s;
    logic [CW-1:0]  ones_next_s;
    logic [CW-1:0]  fill_next_s;
    logic           cmp_s;
    logic           match_s;

    // Post-accept window view: the oldest bit only leaves the count once the window is full.
    always_comb begin
        full_s = (fill_r == WIN_CW);
        add_s  = {{(CW-1){1'b0}}, serial_pattern};
        if (full_s) begin
            drop_s      = {{(CW-1){1'b0}}, hist_r[WIN-1]};
            fill_next_s = fill_r;
        end else begin
            drop_s      = {CW{1'b0}};
            fill_next_s = fill_r + ONE_CW;
        end
        ones_next_s = ones_r + add_s - drop_s;
        if (cmp_mode) begin
            cmp_s = (ones_next_s >= target_count);
        end else begin
            cmp_s = (ones_next_s == target_count);
        end
        match_s = (fill_next_s == WIN_CW) && cmp_s;
    end

    // Window history, fill tracking, running count and registered match pulse.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hist_r             <= {WIN{1'b0}};
            fill_r             <= {CW{1'b0}};
            ones_r             <= {CW{1'b0}};
            window_full_r      <= 1'b0;
            pattern_detected_r <= 1'b0;
        end else if (!enable) begin
            hist_r             <= {WIN{1'b0}};
            fill_r             <= {CW{1'b0}};
            ones_r             <= {CW{1'b0}};
            window_full_r      <= 1'b0;
            pattern_detected_r <= 1'b0;
        end else if (in_valid) begin
            hist_r             <= {hist_r[WIN-2:0], serial_pattern};
            fill_r             <= fill_next_s;
            ones_r             <= ones_next_s;
            window_full_r      <= (fill_next_s == WIN_CW);
            pattern_detected_r <= match_s;
        end else begin
            pattern_detected_r <= 1'b0;
        end
    end

    assign pattern_detected = pattern_detected_r;
    assign window_full      = window_full_r;
    assign ones_count       = ones_r;

`ifdef WCD_HIT_CNT_EN
    localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};
    localparam logic [HIT_W-1:0] HIT_ONE = {{(HIT_W-1){1'b0}}, 1'b1};

    logic [HIT_W-1:0] hit_r;

    // Counts registered pulses, so it trails pattern_detected by one cycle; saturates.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hit_r <= {HIT_W{1'b0}};
        end else if (!enable) begin
            hit_r <= {HIT_W{1'b0}};
        end else if (pattern_detected_r && (hit_r != HIT_MAX)) begin
            hit_r <= hit_r + HIT_ONE;
        end else begin
            hit_r <= hit_r;
        end
    end

    assign hit_count = hit_r;
`endif

endmodule
